// File: rtl/vr_commit_engine.sv
`default_nettype none
// ============================================================================
// Module   : vr_commit_engine
// Purpose  : Marks log headers committed for ops (commit_num, target] on a
//            VR commit message, keeping several header reads in flight and
//            writing back the highest contiguous op committed.
// Revision : 1.0 - initial release
// ============================================================================
module vr_commit_engine #(
    parameter int OP_NUM_W        = 64,
    parameter int LOG_IDX_W       = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_BATCH       = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 msg_val,
    output logic                 msg_rdy,
    input  logic [OP_NUM_W-1:0]  msg_commit_op_num,
    input  logic [OP_NUM_W-1:0]  state_commit_num,
    input  logic [OP_NUM_W-1:0]  state_last_op_num,
    output logic                 state_wr_val,
    input  logic                 state_wr_rdy,
    output logic [OP_NUM_W-1:0]  state_wr_commit_num,
    output logic                 hdr_rd_req_val,
    input  logic                 hdr_rd_req_rdy,
    output logic [LOG_IDX_W-1:0] hdr_rd_req_idx,
    input  logic                 hdr_rd_resp_val,
    output logic                 hdr_rd_resp_rdy,
    input  logic [OP_NUM_W-1:0]  hdr_rd_resp_op_num,
    input  logic                 hdr_rd_resp_present,
    output logic                 hdr_wr_val,
    input  logic                 hdr_wr_rdy,
    output logic [LOG_IDX_W-1:0] hdr_wr_idx,
    output logic [OP_NUM_W-1:0]  hdr_wr_op_num,
    output logic                 hdr_wr_committed,
    output logic                 done_val,
    output logic [1:0]           done_status,
    output logic                 eng_rdy
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_run      = 3'd1;
    localparam logic [2:0] c_drain    = 3'd2;
    localparam logic [2:0] c_state_wr = 3'd3;
    localparam logic [2:0] c_done     = 3'd4;

    localparam logic [OUT_W-1:0]    c_max_out = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OP_NUM_W-1:0] c_batch   = OP_NUM_W'(MAX_BATCH);

    generate
        if (MAX_BATCH > (1 << LOG_IDX_W) || MAX_BATCH < 1) begin : g_bad_batch
            $error("vr_commit_engine: MAX_BATCH must lie in 1..2^LOG_IDX_W");
        end
        if (MAX_OUTSTANDING < 1) begin : g_bad_outstanding
            $error("vr_commit_engine: MAX_OUTSTANDING must be at least 1");
        end
    endgenerate

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [OP_NUM_W-1:0]  r_start;
    logic [OP_NUM_W-1:0]  r_target;
    logic [OP_NUM_W-1:0]  r_rd_op;
    logic [OP_NUM_W-1:0]  r_chk_op;
    logic [OP_NUM_W-1:0]  r_committed;
    logic [OP_NUM_W-1:0]  r_wr_op;
    logic [LOG_IDX_W-1:0] r_wr_idx;
    logic [OUT_W-1:0]     r_outstanding;
    logic                 r_wr_pend;
    logic                 r_abort;
    logic                 r_partial;
    logic                 r_stale;

    logic [OP_NUM_W-1:0]  w_lim;
    logic [OP_NUM_W-1:0]  w_tgt;
    logic [OP_NUM_W-1:0]  w_committed_nxt;
    logic [OUT_W-1:0]     w_out_nxt;
    logic                 w_idle, w_run, w_drain;
    logic                 w_msg_fire, w_rd_fire, w_resp_fire, w_resp_cnt, w_wr_fire;
    logic                 w_resp_match, w_good, w_bad, w_pend_nxt;
    logic [1:0]           w_status;

    // IDLE is the reset state, so it is qualified by rst to keep the ready
    // outputs low while reset is held.
    assign w_idle  = rst & (r_state == c_idle);
    assign w_run   = (r_state == c_run);
    assign w_drain = (r_state == c_drain);

    assign msg_rdy         = w_idle;
    assign eng_rdy         = w_idle;
    assign hdr_rd_req_val  = w_run & ~r_abort & (r_rd_op <= r_target) & (r_outstanding < c_max_out);
    assign hdr_rd_req_idx  = r_rd_op[LOG_IDX_W-1:0];
    assign hdr_rd_resp_rdy = w_idle | w_drain | (w_run & ~r_wr_pend);
    assign hdr_wr_val      = w_run & r_wr_pend;
    assign hdr_wr_idx      = r_wr_idx;
    assign hdr_wr_op_num   = r_wr_op;
    assign hdr_wr_committed = 1'b1;
    assign state_wr_val    = (r_state == c_state_wr) & (r_committed != r_start);
    assign state_wr_commit_num = r_committed;
    assign done_val        = (r_state == c_done);
    assign w_status        = r_stale ? 2'b11 : r_abort ? 2'b10 : r_partial ? 2'b01 : 2'b00;
    assign done_status     = done_val ? w_status : 2'b00;

    assign w_msg_fire   = msg_val & msg_rdy;
    assign w_rd_fire    = hdr_rd_req_val & hdr_rd_req_rdy;
    assign w_resp_fire  = hdr_rd_resp_val & hdr_rd_resp_rdy;
    // Responses seen in IDLE are leftovers and do not belong to the count.
    assign w_resp_cnt   = w_resp_fire & (w_run | w_drain);
    assign w_wr_fire    = hdr_wr_val & hdr_wr_rdy;
    assign w_resp_match = hdr_rd_resp_present & (hdr_rd_resp_op_num == r_chk_op);
    // Once aborted, any response still arriving in RUN is simply discarded.
    assign w_good       = w_run & ~r_abort & w_resp_fire & w_resp_match;
    assign w_bad        = w_run & ~r_abort & w_resp_fire & ~w_resp_match;

    assign w_committed_nxt = w_wr_fire ? r_wr_op : r_committed;
    assign w_pend_nxt      = (r_wr_pend & ~w_wr_fire) | w_good;
    assign w_out_nxt       = r_outstanding + OUT_W'(w_rd_fire) - OUT_W'(w_resp_cnt);

    // Batch target: the smallest of message point, log end and batch limit.
    always_comb begin
        w_lim = state_commit_num + c_batch;
        w_tgt = msg_commit_op_num;
        if (state_last_op_num < w_tgt) w_tgt = state_last_op_num;
        if (w_lim < w_tgt)             w_tgt = w_lim;
    end

    // Next-state selection; the RUN exit looks one cycle ahead so the state
    // write follows the final header write immediately.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_msg_fire) w_next_state = (w_tgt <= state_commit_num) ? c_done : c_run;
            end
            c_run: begin
                if ((w_bad | r_abort) & ~w_pend_nxt)
                    w_next_state = c_drain;
                else if ((w_committed_nxt == r_target) & ~w_pend_nxt & (w_out_nxt == '0))
                    w_next_state = c_state_wr;
            end
            c_drain: begin
                if (r_outstanding == '0) w_next_state = c_state_wr;
            end
            c_state_wr: begin
                if ((r_committed == r_start) | state_wr_rdy) w_next_state = c_done;
            end
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // State, batch bookkeeping and the single-entry header write register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_idle;
            r_start       <= '0;
            r_target      <= '0;
            r_rd_op       <= '0;
            r_chk_op      <= '0;
            r_committed   <= '0;
            r_wr_op       <= '0;
            r_wr_idx      <= '0;
            r_outstanding <= '0;
            r_wr_pend     <= 1'b0;
            r_abort       <= 1'b0;
            r_partial     <= 1'b0;
            r_stale       <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_outstanding <= w_out_nxt;
            if (w_msg_fire) begin
                r_start     <= state_commit_num;
                r_target    <= w_tgt;
                r_partial   <= (w_tgt < msg_commit_op_num);
                r_stale     <= (w_tgt <= state_commit_num);
                r_abort     <= 1'b0;
                r_wr_pend   <= 1'b0;
                r_rd_op     <= state_commit_num + 1'b1;
                r_chk_op    <= state_commit_num + 1'b1;
                r_committed <= state_commit_num;
            end else if (w_run) begin
                r_wr_pend   <= w_pend_nxt;
                r_committed <= w_committed_nxt;
                if (w_rd_fire) r_rd_op <= r_rd_op + 1'b1;
                if (w_bad)     r_abort <= 1'b1;
                if (w_good) begin
                    r_wr_idx <= r_chk_op[LOG_IDX_W-1:0];
                    r_wr_op  <= r_chk_op;
                    r_chk_op <= r_chk_op + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vr_commit_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_vr_commit_engine
// Purpose  : Self-checking bench for vr_commit_engine: directed vector table,
//            hand-written stall/reset sequence and randomized transactions
//            checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vr_commit_engine;

    localparam int MO = 4;
    localparam int MB = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_val;
    logic        msg_rdy;
    logic [63:0] msg_commit_op_num;
    logic [63:0] state_commit_num;
    logic [63:0] state_last_op_num;
    logic        state_wr_val;
    logic        state_wr_rdy;
    logic [63:0] state_wr_commit_num;
    logic        hdr_rd_req_val;
    logic        hdr_rd_req_rdy;
    logic [7:0]  hdr_rd_req_idx;
    logic        hdr_rd_resp_val;
    logic        hdr_rd_resp_rdy;
    logic [63:0] hdr_rd_resp_op_num;
    logic        hdr_rd_resp_present;
    logic        hdr_wr_val;
    logic        hdr_wr_rdy;
    logic [7:0]  hdr_wr_idx;
    logic [63:0] hdr_wr_op_num;
    logic        hdr_wr_committed;
    logic        done_val;
    logic [1:0]  done_status;
    logic        eng_rdy;

    always #5 clk = ~clk;

    vr_commit_engine #(
        .OP_NUM_W(64), .LOG_IDX_W(8), .MAX_OUTSTANDING(MO), .MAX_BATCH(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .msg_val(msg_val), .msg_rdy(msg_rdy), .msg_commit_op_num(msg_commit_op_num),
        .state_commit_num(state_commit_num), .state_last_op_num(state_last_op_num),
        .state_wr_val(state_wr_val), .state_wr_rdy(state_wr_rdy),
        .state_wr_commit_num(state_wr_commit_num),
        .hdr_rd_req_val(hdr_rd_req_val), .hdr_rd_req_rdy(hdr_rd_req_rdy),
        .hdr_rd_req_idx(hdr_rd_req_idx),
        .hdr_rd_resp_val(hdr_rd_resp_val), .hdr_rd_resp_rdy(hdr_rd_resp_rdy),
        .hdr_rd_resp_op_num(hdr_rd_resp_op_num), .hdr_rd_resp_present(hdr_rd_resp_present),
        .hdr_wr_val(hdr_wr_val), .hdr_wr_rdy(hdr_wr_rdy), .hdr_wr_idx(hdr_wr_idx),
        .hdr_wr_op_num(hdr_wr_op_num), .hdr_wr_committed(hdr_wr_committed),
        .done_val(done_val), .done_status(done_status), .eng_rdy(eng_rdy)
    );

    // Log-header ring contents
    logic        mem_p  [0:255];
    logic [63:0] mem_op [0:255];

    typedef struct {
        logic [7:0] idx;
        int         rdy_cyc;
    } rd_t;
    rd_t rdq[$];

    logic [7:0]  wlog_idx[$];
    logic [63:0] wlog_op[$];
    logic [63:0] slog[$];

    int  n_checks, n_pass, cyc, n_rd, n_out, max_out, acc_cyc, done_cyc, n_stab;
    bit  done_seen, rand_mode, force_wr_low;
    logic [1:0] done_st;

    bit          s_msg, s_rd, s_resp, s_wr, s_swr, s_done, s_wr_hold;
    logic [7:0]  s_rd_idx, s_wr_idx;
    logic [63:0] s_wr_op, s_swr_num;
    logic [1:0]  s_st;

    typedef struct {
        logic [63:0] start;
        logic [63:0] msg;
        logic [63:0] last;
        logic [63:0] hole;
        int          kind;
        logic [1:0]  st;
        logic [63:0] commit;
        int          nwr;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // One clock: snapshot handshakes before the edge, account for them after
    // it at the falling edge, then drive the memory side for the next edge.
    task automatic tick();
        #1;
        s_msg     = msg_val & msg_rdy;
        s_rd      = hdr_rd_req_val & hdr_rd_req_rdy;
        s_rd_idx  = hdr_rd_req_idx;
        s_resp    = hdr_rd_resp_val & hdr_rd_resp_rdy;
        s_wr      = hdr_wr_val & hdr_wr_rdy;
        s_wr_hold = hdr_wr_val & ~hdr_wr_rdy;
        s_wr_idx  = hdr_wr_idx;
        s_wr_op   = hdr_wr_op_num;
        s_swr     = state_wr_val & state_wr_rdy;
        s_swr_num = state_wr_commit_num;
        s_done    = done_val;
        s_st      = done_status;
        @(negedge clk);
        cyc++;
        if (s_wr_hold && rst) begin
            n_stab++;
            check("wr_hold_val", 64'(hdr_wr_val), 1);
            check("wr_hold_idx", 64'(hdr_wr_idx), 64'(s_wr_idx));
            check("wr_hold_op", hdr_wr_op_num, s_wr_op);
        end
        if (s_msg) begin
            acc_cyc = cyc;
            msg_val = 1'b0;
        end
        if (s_resp) begin
            if (rdq.size() > 0) void'(rdq.pop_front());
            n_out--;
        end
        if (s_rd) begin
            n_rd++;
            n_out++;
            if (n_out > max_out) max_out = n_out;
            rdq.push_back('{idx: s_rd_idx, rdy_cyc: cyc + (rand_mode ? int'($urandom_range(0, 3)) : 0)});
        end
        if (s_wr) begin
            wlog_idx.push_back(s_wr_idx);
            wlog_op.push_back(s_wr_op);
        end
        if (s_swr) slog.push_back(s_swr_num);
        if (s_done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            done_st   = s_st;
        end
        hdr_rd_req_rdy = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        hdr_wr_rdy     = force_wr_low ? 1'b0 : rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        state_wr_rdy   = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (rdq.size() > 0 && rdq[0].rdy_cyc <= cyc) begin
            hdr_rd_resp_val     = 1'b1;
            hdr_rd_resp_present = mem_p[rdq[0].idx];
            hdr_rd_resp_op_num  = mem_op[rdq[0].idx];
        end else begin
            hdr_rd_resp_val     = 1'b0;
            hdr_rd_resp_present = 1'b0;
            hdr_rd_resp_op_num  = '0;
        end
    endtask

    // kind 0: all entries good, 1: hole_op absent, 2: hole_op holds another op
    task automatic fill_mem(input logic [63:0] start, input logic [63:0] hole_op, input int kind);
        logic [63:0] op;
        for (int i = 0; i < 256; i++) begin
            mem_p[i]  = 1'b0;
            mem_op[i] = '0;
        end
        for (int i = 1; i <= MB; i++) begin
            op = start + 64'(i);
            mem_p[op[7:0]]  = 1'b1;
            mem_op[op[7:0]] = op;
        end
        if (kind == 1) mem_p[hole_op[7:0]] = 1'b0;
        if (kind == 2) mem_op[hole_op[7:0]] = hole_op + 64'd256;
    endtask

    task automatic clear_logs();
        wlog_idx.delete();
        wlog_op.delete();
        slog.delete();
        done_seen = 1'b0;
        n_rd = 0;
        n_out = 0;
        max_out = 0;
        acc_cyc = -100;
        done_cyc = 0;
    endtask

    task automatic run_txn(input logic [63:0] start, input logic [63:0] msg, input logic [63:0] last);
        clear_logs();
        state_commit_num  = start;
        state_last_op_num = last;
        msg_commit_op_num = msg;
        msg_val = 1'b1;
        for (int i = 0; i < 3000 && !done_seen; i++) tick();
        check("done_seen", 64'(done_seen), 1);
        msg_val = 1'b0;
        tick();
        tick();
    endtask

    // Behavioural model: walk ops start+1..target in the ring and stop at the
    // first entry that is absent or carries the wrong op.
    task automatic check_model(input string tag, input logic [63:0] start,
                               input logic [63:0] msg, input logic [63:0] last);
        logic [63:0] tgt, good_to, op, e;
        logic [1:0]  st;
        bit          hole;
        int          nexp;
        tgt = msg;
        if (last < tgt) tgt = last;
        if (start + 64'(MB) < tgt) tgt = start + 64'(MB);
        good_to = start;
        hole = 1'b0;
        if (tgt <= start) begin
            st = 2'b11;
        end else begin
            op = start + 64'd1;
            while (op <= tgt && !hole) begin
                if (mem_p[op[7:0]] && mem_op[op[7:0]] == op) begin
                    good_to = op;
                    op++;
                end else begin
                    hole = 1'b1;
                end
            end
            st = hole ? 2'b10 : (tgt < msg) ? 2'b01 : 2'b00;
        end
        nexp = int'(good_to - start);
        check({tag, "_status"}, 64'(done_st), 64'(st));
        check({tag, "_nwrites"}, 64'(wlog_op.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < wlog_op.size(); i++) begin
            e = start + 64'(i + 1);
            check({tag, "_wr_op"}, wlog_op[i], e);
            check({tag, "_wr_idx"}, 64'(wlog_idx[i]), 64'(e[7:0]));
        end
        check({tag, "_nstate_wr"}, 64'(slog.size()), (good_to != start) ? 64'd1 : 64'd0);
        if (slog.size() > 0 && good_to != start) check({tag, "_state_wr"}, slog[0], good_to);
        check({tag, "_max_out_ok"}, 64'(max_out <= MO), 1);
        if (st == 2'b11) begin
            check({tag, "_stale_reads"}, 64'(n_rd), 0);
            check({tag, "_stale_lat"}, 64'(done_cyc - acc_cyc), 1);
        end
    endtask

    task automatic check_rst_outputs(input string tag);
        check({tag, "_ctl"}, 64'({msg_rdy, state_wr_val, hdr_rd_req_val, hdr_rd_resp_rdy,
                                  hdr_wr_val, done_val, eng_rdy, done_status}), 0);
        check({tag, "_swr_num"}, state_wr_commit_num, 0);
        check({tag, "_wr_op"}, hdr_wr_op_num, 0);
        check({tag, "_idx"}, 64'({hdr_rd_req_idx, hdr_wr_idx}), 0);
        check({tag, "_committed"}, 64'(hdr_wr_committed), 1);
    endtask

    initial begin
        logic [63:0] st_r, msg_r, last_r, hole_r;
        int          kind_r, stab0;

        n_checks = 0; n_pass = 0; cyc = 0; n_stab = 0;
        rand_mode = 1'b0; force_wr_low = 1'b0;
        rst = 1'b0; msg_val = 1'b0;
        msg_commit_op_num = '0; state_commit_num = '0; state_last_op_num = '0;
        state_wr_rdy = 1'b1; hdr_rd_req_rdy = 1'b1; hdr_wr_rdy = 1'b1;
        hdr_rd_resp_val = 1'b0; hdr_rd_resp_op_num = '0; hdr_rd_resp_present = 1'b0;
        clear_logs();

        tbl[0] = '{64'd10,  64'd13,  64'd20,  64'd0,  0, 2'b00, 64'd13,  3};
        tbl[1] = '{64'd0,   64'd100, 64'd100, 64'd0,  0, 2'b01, 64'd64,  64};
        tbl[2] = '{64'd20,  64'd25,  64'd30,  64'd23, 1, 2'b10, 64'd22,  2};
        tbl[3] = '{64'd20,  64'd25,  64'd30,  64'd21, 1, 2'b10, 64'd20,  0};
        tbl[4] = '{64'd254, 64'd258, 64'd300, 64'd0,  0, 2'b00, 64'd258, 4};
        tbl[5] = '{64'd7,   64'd5,   64'd20,  64'd0,  0, 2'b11, 64'd7,   0};
        tbl[6] = '{64'd10,  64'd20,  64'd15,  64'd0,  0, 2'b01, 64'd15,  5};
        tbl[7] = '{64'd30,  64'd33,  64'd40,  64'd32, 2, 2'b10, 64'd31,  1};
        tbl[8] = '{64'd5,   64'd5,   64'd9,   64'd0,  0, 2'b11, 64'd5,   0};
        tbl[9] = '{64'd50,  64'd60,  64'd52,  64'd0,  0, 2'b01, 64'd52,  2};

        // Reset state
        tick(); tick();
        check_rst_outputs("reset");
        rst = 1'b1;
        tick();
        check("reset_eng_rdy", 64'(eng_rdy), 1);
        check("reset_msg_rdy", 64'(msg_rdy), 1);

        // Directed vectors, memory with one-cycle latency and all ready high
        for (int t = 0; t < 10; t++) begin
            fill_mem(tbl[t].start, tbl[t].hole, tbl[t].kind);
            run_txn(tbl[t].start, tbl[t].msg, tbl[t].last);
            check($sformatf("tbl%0d_status", t), 64'(done_st), 64'(tbl[t].st));
            check($sformatf("tbl%0d_nwr", t), 64'(wlog_op.size()), 64'(tbl[t].nwr));
            check($sformatf("tbl%0d_commit", t), (slog.size() > 0) ? slog[0] : tbl[t].start,
                  tbl[t].commit);
            check_model($sformatf("tbl%0d", t), tbl[t].start, tbl[t].msg, tbl[t].last);
        end

        // Write stalled mid-batch, then reset while the batch is running
        fill_mem(64'd100, 64'd0, 0);
        clear_logs();
        state_commit_num = 64'd100; state_last_op_num = 64'd200; msg_commit_op_num = 64'd140;
        msg_val = 1'b1;
        for (int i = 0; i < 200 && wlog_op.size() < 3; i++) tick();
        check("seq_three_writes", 64'(wlog_op.size()), 3);
        force_wr_low = 1'b1;
        stab0 = n_stab;
        for (int i = 0; i < 10; i++) tick();
        check("seq_hold_seen", 64'(n_stab - stab0 >= 8), 1);
        check("seq_wr_still_val", 64'(hdr_wr_val), 1);
        check("seq_eng_busy", 64'(eng_rdy), 0);
        check("seq_nwr_during_stall", 64'(wlog_op.size()), 3);
        rst = 1'b0;
        msg_val = 1'b0;
        force_wr_low = 1'b0;
        rdq.delete();
        hdr_rd_resp_val = 1'b0;
        hdr_rd_resp_present = 1'b0;
        hdr_rd_resp_op_num = '0;
        #1;
        check_rst_outputs("seq_rst");
        tick(); tick();
        check_rst_outputs("seq_rst_hold");
        rst = 1'b1;
        tick();
        check("seq_eng_rdy_after", 64'(eng_rdy), 1);
        for (int i = 0; i < 20; i++) tick();
        check("seq_no_state_wr", 64'(slog.size()), 0);
        check("seq_no_done", 64'(done_seen), 0);

        // Randomized transactions with random ready/latency behaviour
        rand_mode = 1'b1;
        for (int t = 0; t < 40; t++) begin
            st_r   = 64'd10 + 64'($urandom_range(0, 2000));
            msg_r  = st_r - 64'd3 + 64'($urandom_range(0, 80));
            last_r = st_r - 64'd2 + 64'($urandom_range(0, 90));
            kind_r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
            hole_r = st_r + 64'd1 + 64'($urandom_range(0, 30));
            fill_mem(st_r, hole_r, kind_r);
            run_txn(st_r, msg_r, last_r);
            check_model($sformatf("rnd%0d", t), st_r, msg_r, last_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
